// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcode/funct values,
// ALU / write-back / jump / MDU select encodings and the per-stage
// control bundles carried through ID/EX, EX/MEM and MEM/WB.
package pipe_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL funct codes
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_LUI  = 3'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_DM   = 2'd1,
        WD_PC8  = 2'd2,
        WD_HILO = 2'd3
    } wd_sel_e;

    typedef enum logic [1:0] {
        JMP_PC4 = 2'd0,
        JMP_BR  = 2'd1,
        JMP_J   = 2'd2,
        JMP_JR  = 2'd3
    } jump_sel_e;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    // Full bundle decoded in ID and held in ID/EX
    typedef struct packed {
        alu_op_e    alu_op;
        logic       alub_sel;
        mdu_op_e    mdu_op;
        logic       dm_we;
        logic       dm_re;
        logic       grf_we;
        wd_sel_e    wd_sel;
        logic [4:0] a3;
    } ctrl_e_t;

    // Fields still needed after EX
    typedef struct packed {
        logic       dm_we;
        logic       dm_re;
        logic       grf_we;
        wd_sel_e    wd_sel;
        logic [4:0] a3;
    } ctrl_m_t;

    // Fields still needed in WB
    typedef struct packed {
        logic       grf_we;
        wd_sel_e    wd_sel;
        logic [4:0] a3;
    } ctrl_w_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // mult/multu/div/divu occupy the MDU; mthi/mtlo do not
    function automatic logic is_mdu_start(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Down-counter modelling multiply/divide unit occupancy. A start pulse
// loads the op latency; the counter then runs down to zero and busy is
// high while it is non-zero.
module mdu_busy_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         busy
);

    logic [W-1:0] count;

    // Load on start, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage MIPS pipeline: ID decode, ID branch/jump
// resolution, load-use and MDU stall detection, and the E/M/W control
// registers. Optional macro PIPE_CTRL_BRANCH_EXT_EN adds bne, bgez, bgtz,
// blez and bltz; without it those encodings decode as nop.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_d,
    input  logic        cmp_eq,
    input  logic        cmp_gt,
    input  logic        cmp_lt,
    output logic        stall,
    output logic [1:0]  jump_ctrl_d,
    output logic        ext_ctrl_d,
    output logic [2:0]  alu_ctrl_e,
    output logic        alub_sel_e,
    output logic [2:0]  mdu_op_e,
    output logic        dm_we_m,
    output logic        dm_re_m,
    output logic        grf_we_w,
    output logic [1:0]  wd_sel_w,
    output logic [4:0]  a3_e,
    output logic [4:0]  a3_m,
    output logic [4:0]  a3_w,
    output logic        mdu_busy
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [5:0] op;
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] funct;

    assign op    = instr_d[31:26];
    assign rs    = instr_d[25:21];
    assign rt    = instr_d[20:16];
    assign rd    = instr_d[15:11];
    assign shamt = instr_d[10:6];
    assign funct = instr_d[5:0];

    ctrl_e_t    ctrl_d;
    ctrl_e_t    ctrl_e;
    ctrl_m_t    ctrl_m;
    ctrl_w_t    ctrl_w;
    jump_sel_e  jump_sel;
    logic       ext_d;
    logic       rs_t0, rs_t1, rt_t0, rt_t1;
    logic       mdu_class;
    logic       writes;
    logic [4:0] dst;
    logic       r_alu;
    alu_op_e    alu_r;

`ifndef PIPE_CTRL_BRANCH_EXT_EN
    // Comparator flags other than cmp_eq only feed the extended branches
    logic unused_cmp;
    assign unused_cmp = cmp_gt ^ cmp_lt;
`endif

    // ID decode: control bundle, branch/jump select and source-use times
    always_comb begin
        ctrl_d    = '0;
        jump_sel  = JMP_PC4;
        ext_d     = 1'b0;
        rs_t0     = 1'b0;
        rs_t1     = 1'b0;
        rt_t0     = 1'b0;
        rt_t1     = 1'b0;
        mdu_class = 1'b0;
        writes    = 1'b0;
        dst       = 5'd0;
        r_alu     = 1'b0;
        alu_r     = ALU_ADD;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU:  begin r_alu = 1'b1; alu_r = ALU_ADD;  end
                    F_SUBU:  begin r_alu = 1'b1; alu_r = ALU_SUB;  end
                    F_AND:   begin r_alu = 1'b1; alu_r = ALU_AND;  end
                    F_OR:    begin r_alu = 1'b1; alu_r = ALU_OR;   end
                    F_SLT:   begin r_alu = 1'b1; alu_r = ALU_SLT;  end
                    F_SLTU:  begin r_alu = 1'b1; alu_r = ALU_SLTU; end
                    F_JR: begin
                        jump_sel = JMP_JR;
                        rs_t0    = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        writes        = 1'b1;
                        dst           = rd;
                        ctrl_d.wd_sel = WD_HILO;
                        mdu_class     = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        ctrl_d.mdu_op = (funct == F_MTHI) ? MDU_MTHI : MDU_MTLO;
                        rs_t1         = 1'b1;
                        mdu_class     = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        case (funct)
                            F_MULT:  ctrl_d.mdu_op = MDU_MULT;
                            F_MULTU: ctrl_d.mdu_op = MDU_MULTU;
                            F_DIV:   ctrl_d.mdu_op = MDU_DIV;
                            default: ctrl_d.mdu_op = MDU_DIVU;
                        endcase
                        rs_t1     = 1'b1;
                        rt_t1     = 1'b1;
                        mdu_class = 1'b1;
                    end
                    default: ;
                endcase
                // Non-shift R-type ALU ops are only legal with shamt = 0
                if (r_alu && shamt == 5'd0) begin
                    ctrl_d.alu_op = alu_r;
                    writes        = 1'b1;
                    dst           = rd;
                    rs_t1         = 1'b1;
                    rt_t1         = 1'b1;
                end
            end
            OP_ORI: begin
                ctrl_d.alu_op   = ALU_OR;
                ctrl_d.alub_sel = 1'b1;
                writes          = 1'b1;
                dst             = rt;
                rs_t1           = 1'b1;
            end
            OP_ADDIU: begin
                ctrl_d.alu_op   = ALU_ADD;
                ctrl_d.alub_sel = 1'b1;
                ext_d           = 1'b1;
                writes          = 1'b1;
                dst             = rt;
                rs_t1           = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.alu_op   = ALU_LUI;
                ctrl_d.alub_sel = 1'b1;
                writes          = 1'b1;
                dst             = rt;
            end
            OP_LW: begin
                ctrl_d.alub_sel = 1'b1;
                ctrl_d.dm_re    = 1'b1;
                ctrl_d.wd_sel   = WD_DM;
                ext_d           = 1'b1;
                writes          = 1'b1;
                dst             = rt;
                rs_t1           = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alub_sel = 1'b1;
                ctrl_d.dm_we    = 1'b1;
                ext_d           = 1'b1;
                rs_t1           = 1'b1;
                rt_t1           = 1'b1;
            end
            OP_BEQ: begin
                ext_d    = 1'b1;
                jump_sel = cmp_eq ? JMP_BR : JMP_PC4;
                rs_t0    = 1'b1;
                rt_t0    = 1'b1;
            end
            OP_J: begin
                jump_sel = JMP_J;
            end
            OP_JAL: begin
                jump_sel      = JMP_J;
                ctrl_d.wd_sel = WD_PC8;
                writes        = 1'b1;
                dst           = 5'd31;
            end
`ifdef PIPE_CTRL_BRANCH_EXT_EN
            OP_BNE: begin
                ext_d    = 1'b1;
                jump_sel = !cmp_eq ? JMP_BR : JMP_PC4;
                rs_t0    = 1'b1;
                rt_t0    = 1'b1;
            end
            OP_BLEZ: begin
                ext_d    = 1'b1;
                jump_sel = !cmp_gt ? JMP_BR : JMP_PC4;
                rs_t0    = 1'b1;
            end
            OP_BGTZ: begin
                ext_d    = 1'b1;
                jump_sel = cmp_gt ? JMP_BR : JMP_PC4;
                rs_t0    = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ) begin
                    ext_d    = 1'b1;
                    jump_sel = cmp_lt ? JMP_BR : JMP_PC4;
                    rs_t0    = 1'b1;
                end else if (rt == RT_BGEZ) begin
                    ext_d    = 1'b1;
                    jump_sel = !cmp_lt ? JMP_BR : JMP_PC4;
                    rs_t0    = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        // $0 is never written: drop the enable and report no destination
        ctrl_d.grf_we = writes && (dst != 5'd0);
        ctrl_d.a3     = ctrl_d.grf_we ? dst : 5'd0;
    end

    logic e_lw, m_lw, e_alu_wr, e_mdu_start;
    logic stall_lu, stall_mdu;

    assign e_lw        = ctrl_e.dm_re && (ctrl_e.a3 != 5'd0);
    assign m_lw        = ctrl_m.dm_re && (ctrl_m.a3 != 5'd0);
    assign e_alu_wr    = ctrl_e.grf_we && (ctrl_e.a3 != 5'd0) &&
                         (ctrl_e.wd_sel == WD_ALU || ctrl_e.wd_sel == WD_HILO);
    assign e_mdu_start = is_mdu_start(ctrl_e.mdu_op);

    // Hazard detection: load-use against E and M, ALU result not yet ready for ID compare
    always_comb begin
        stall_lu = 1'b0;
        if (e_lw && (((rs_t0 || rs_t1) && rs == ctrl_e.a3) ||
                     ((rt_t0 || rt_t1) && rt == ctrl_e.a3)))
            stall_lu = 1'b1;
        if (m_lw && ((rs_t0 && rs == ctrl_m.a3) || (rt_t0 && rt == ctrl_m.a3)))
            stall_lu = 1'b1;
        if (e_alu_wr && ((rs_t0 && rs == ctrl_e.a3) || (rt_t0 && rt == ctrl_e.a3)))
            stall_lu = 1'b1;
        stall_mdu = mdu_class && (mdu_busy || e_mdu_start);
        stall     = stall_lu || stall_mdu;
    end

    mdu_busy_timer #(
        .W (CNT_W)
    ) u_mdu_busy_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (e_mdu_start),
        .load_val ((ctrl_e.mdu_op == MDU_DIV || ctrl_e.mdu_op == MDU_DIVU) ?
                   CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
        .busy     (mdu_busy)
    );

    // Pipeline registers: bubble into EX on stall, M and W always advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_e <= '0;
            ctrl_m <= '0;
            ctrl_w <= '0;
        end else begin
            ctrl_e        <= stall ? '0 : ctrl_d;
            ctrl_m.dm_we  <= ctrl_e.dm_we;
            ctrl_m.dm_re  <= ctrl_e.dm_re;
            ctrl_m.grf_we <= ctrl_e.grf_we;
            ctrl_m.wd_sel <= ctrl_e.wd_sel;
            ctrl_m.a3     <= ctrl_e.a3;
            ctrl_w.grf_we <= ctrl_m.grf_we;
            ctrl_w.wd_sel <= ctrl_m.wd_sel;
            ctrl_w.a3     <= ctrl_m.a3;
        end
    end

    assign jump_ctrl_d = jump_sel;
    assign ext_ctrl_d  = ext_d;
    assign alu_ctrl_e  = ctrl_e.alu_op;
    assign alub_sel_e  = ctrl_e.alub_sel;
    assign mdu_op_e    = ctrl_e.mdu_op;
    assign a3_e        = ctrl_e.a3;
    assign dm_we_m     = ctrl_m.dm_we;
    assign dm_re_m     = ctrl_m.dm_re;
    assign a3_m        = ctrl_m.a3;
    assign grf_we_w    = ctrl_w.grf_we;
    assign wd_sel_w    = ctrl_w.wd_sel;
    assign a3_w        = ctrl_w.a3;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, decode, load-use and MDU
// stalls, branch/jump selection, $0 writes and the optional extended
// branches (PIPE_CTRL_BRANCH_EXT_EN).
module tb_pipe_ctrl_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr_d;
    logic        cmp_eq, cmp_gt, cmp_lt;
    logic        stall;
    logic [1:0]  jump_ctrl_d;
    logic        ext_ctrl_d;
    logic [2:0]  alu_ctrl_e;
    logic        alub_sel_e;
    logic [2:0]  mdu_op_e;
    logic        dm_we_m, dm_re_m, grf_we_w;
    logic [1:0]  wd_sel_w;
    logic [4:0]  a3_e, a3_m, a3_w;
    logic        mdu_busy;

    int vectors;
    int miscompares;
    logic [4:0] exp_q[$];

    pipe_ctrl_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_d     (instr_d),
        .cmp_eq      (cmp_eq),
        .cmp_gt      (cmp_gt),
        .cmp_lt      (cmp_lt),
        .stall       (stall),
        .jump_ctrl_d (jump_ctrl_d),
        .ext_ctrl_d  (ext_ctrl_d),
        .alu_ctrl_e  (alu_ctrl_e),
        .alub_sel_e  (alub_sel_e),
        .mdu_op_e    (mdu_op_e),
        .dm_we_m     (dm_we_m),
        .dm_re_m     (dm_re_m),
        .grf_we_w    (grf_we_w),
        .wd_sel_w    (wd_sel_w),
        .a3_e        (a3_e),
        .a3_m        (a3_m),
        .a3_w        (a3_w),
        .mdu_busy    (mdu_busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        instr_d = 32'd0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        instr_d = 32'd0;
        repeat (2) tick();
        if (a3_e !== 5'd0 || a3_w !== 5'd0 || stall !== 1'b0 || mdu_busy !== 1'b0) begin
            $display("FAIL reset_init: a3_e=%0d a3_w=%0d stall=%0b busy=%0b expected all 0",
                     a3_e, a3_w, stall, mdu_busy);
            miscompares++;
        end
        vectors++;
        reset_n = 1'b1;
        instr_d = r_type(1, 2, 0, 'h18);           // mult $1,$2
        tick();
        instr_d = i_type('h23, 1, 8, 0);           // lw $8,0($1)
        tick();
        instr_d = i_type('h23, 1, 9, 0);           // lw $9,0($1)
        tick();
        instr_d = r_type(9, 9, 10, 'h21);          // addu $10,$9,$9
        #1;
        if (stall !== 1'b1 || mdu_busy !== 1'b1 || dm_re_m !== 1'b1 || a3_e !== 5'd9) begin
            $display("FAIL reset_pre: stall=%0b busy=%0b dm_re_m=%0b a3_e=%0d expected 1 1 1 9",
                     stall, mdu_busy, dm_re_m, a3_e);
            miscompares++;
        end
        vectors++;
        #2;
        reset_n = 1'b0;
        #1;
        if (a3_e !== 5'd0 || dm_re_m !== 1'b0 || mdu_busy !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL reset_async: a3_e=%0d dm_re_m=%0b busy=%0b stall=%0b expected all 0",
                     a3_e, dm_re_m, mdu_busy, stall);
            miscompares++;
        end
        vectors++;
        instr_d = 32'd0;
        tick();
        reset_n = 1'b1;
        drain();
    endtask

    task automatic test_load_use();
        int n;
        instr_d = i_type('h23, 1, 8, 4);           // lw $8,4($1)
        #1;
        if (stall !== 1'b0) begin
            $display("FAIL lu_lw_nostall: stall=%0b expected 0", stall);
            miscompares++;
        end
        vectors++;
        tick();
        instr_d = r_type(8, 8, 9, 'h21);           // addu $9,$8,$8
        #1;
        if (stall !== 1'b1) begin
            $display("FAIL lu_stall: stall=%0b expected 1", stall);
            miscompares++;
        end
        vectors++;
        tick();
        if (a3_e !== 5'd0 || stall !== 1'b0 || dm_re_m !== 1'b1 || a3_m !== 5'd8) begin
            $display("FAIL lu_bubble: a3_e=%0d stall=%0b dm_re_m=%0b a3_m=%0d expected 0 0 1 8",
                     a3_e, stall, dm_re_m, a3_m);
            miscompares++;
        end
        vectors++;
        tick();
        if (a3_e !== 5'd9 || a3_w !== 5'd8 || wd_sel_w !== 2'd1 || grf_we_w !== 1'b1) begin
            $display("FAIL lu_advance: a3_e=%0d a3_w=%0d wd_sel_w=%0d grf_we_w=%0b expected 9 8 1 1",
                     a3_e, a3_w, wd_sel_w, grf_we_w);
            miscompares++;
        end
        vectors++;
        drain();
        // lw then beq on the loaded register: two stall cycles
        instr_d = i_type('h23, 1, 8, 0);
        tick();
        instr_d = i_type('h04, 8, 0, 3);           // beq $8,$0
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        if (n != 2) begin
            $display("FAIL lu_beq_stalls: got %0d stall cycles expected 2", n);
            miscompares++;
        end
        vectors++;
        drain();
        // ALU writer in E feeding a branch compare: one stall cycle
        instr_d = r_type(1, 2, 9, 'h21);           // addu $9,$1,$2
        tick();
        instr_d = i_type('h04, 0, 9, 3);           // beq $0,$9
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        if (n != 1) begin
            $display("FAIL alu_beq_stalls: got %0d stall cycles expected 1", n);
            miscompares++;
        end
        vectors++;
        drain();
    endtask

    task automatic test_branch();
        instr_d = i_type('h04, 1, 2, 8);           // beq $1,$2
        cmp_eq  = 1'b1;
        #1;
        if (jump_ctrl_d !== 2'd1 || ext_ctrl_d !== 1'b1) begin
            $display("FAIL beq_taken: jump=%0d ext=%0b expected 1 1", jump_ctrl_d, ext_ctrl_d);
            miscompares++;
        end
        vectors++;
        cmp_eq = 1'b0;
        #1;
        if (jump_ctrl_d !== 2'd0) begin
            $display("FAIL beq_not_taken: jump=%0d expected 0", jump_ctrl_d);
            miscompares++;
        end
        vectors++;
        instr_d = 32'h0800_0010;                   // j
        #1;
        if (jump_ctrl_d !== 2'd2) begin
            $display("FAIL j_sel: jump=%0d expected 2", jump_ctrl_d);
            miscompares++;
        end
        vectors++;
        instr_d = r_type(31, 0, 0, 'h08);          // jr $31
        #1;
        if (jump_ctrl_d !== 2'd3 || stall !== 1'b0) begin
            $display("FAIL jr_sel: jump=%0d stall=%0b expected 3 0", jump_ctrl_d, stall);
            miscompares++;
        end
        vectors++;
        instr_d = 32'h0C00_0010;                   // jal
        tick();
        instr_d = 32'd0;
        tick();
        tick();
        if (a3_w !== 5'd31 || wd_sel_w !== 2'd2 || grf_we_w !== 1'b1) begin
            $display("FAIL jal_wb: a3_w=%0d wd_sel_w=%0d grf_we_w=%0b expected 31 2 1",
                     a3_w, wd_sel_w, grf_we_w);
            miscompares++;
        end
        vectors++;
        drain();
    endtask

    task automatic test_mdu();
        int n;
        int b;
        instr_d = r_type(1, 2, 0, 'h18);           // mult $1,$2
        #1;
        if (stall !== 1'b0) begin
            $display("FAIL mult_nostall: stall=%0b expected 0", stall);
            miscompares++;
        end
        vectors++;
        tick();
        if (mdu_op_e !== 3'd1) begin
            $display("FAIL mult_op_e: mdu_op_e=%0d expected 1", mdu_op_e);
            miscompares++;
        end
        vectors++;
        instr_d = r_type(0, 0, 3, 'h12);           // mflo $3
        #1;
        n = 0;
        b = 0;
        while (stall === 1'b1 && n < 60) begin
            n++;
            if (mdu_busy === 1'b1) b++;
            tick();
        end
        if (n != 6 || b != 5 || mdu_busy !== 1'b0) begin
            $display("FAIL mult_mflo: stalls=%0d busy=%0d end_busy=%0b expected 6 5 0",
                     n, b, mdu_busy);
            miscompares++;
        end
        vectors++;
        tick();
        if (a3_e !== 5'd3 || mdu_op_e !== 3'd0) begin
            $display("FAIL mflo_e: a3_e=%0d mdu_op_e=%0d expected 3 0", a3_e, mdu_op_e);
            miscompares++;
        end
        vectors++;
        instr_d = r_type(4, 5, 0, 'h1a);           // div $4,$5
        tick();
        if (mdu_op_e !== 3'd3) begin
            $display("FAIL div_op_e: mdu_op_e=%0d expected 3", mdu_op_e);
            miscompares++;
        end
        vectors++;
        instr_d = r_type(0, 0, 6, 'h10);           // mfhi $6
        #1;
        n = 0;
        b = 0;
        while (stall === 1'b1 && n < 60) begin
            n++;
            if (mdu_busy === 1'b1) b++;
            tick();
        end
        if (n != 11 || b != 10) begin
            $display("FAIL div_mfhi: stalls=%0d busy=%0d expected 11 10", n, b);
            miscompares++;
        end
        vectors++;
        drain();
    endtask

    task automatic test_zero_write();
        instr_d = r_type(1, 2, 0, 'h21);           // addu $0,$1,$2
        tick();
        if (a3_e !== 5'd0) begin
            $display("FAIL zero_a3_e: a3_e=%0d expected 0", a3_e);
            miscompares++;
        end
        vectors++;
        instr_d = i_type('h04, 0, 0, 2);           // beq $0,$0
        cmp_eq  = 1'b1;
        #1;
        if (stall !== 1'b0 || jump_ctrl_d !== 2'd1) begin
            $display("FAIL zero_beq: stall=%0b jump=%0d expected 0 1", stall, jump_ctrl_d);
            miscompares++;
        end
        vectors++;
        tick();
        instr_d = 32'd0;
        cmp_eq  = 1'b0;
        tick();
        if (a3_w !== 5'd0 || grf_we_w !== 1'b0) begin
            $display("FAIL zero_wb: a3_w=%0d grf_we_w=%0b expected 0 0", a3_w, grf_we_w);
            miscompares++;
        end
        vectors++;
        drain();
    endtask

    task automatic test_decode();
        instr_d = i_type('h0d, 1, 4, 5);           // ori $4,$1,5
        #1;
        if (ext_ctrl_d !== 1'b0) begin
            $display("FAIL ori_ext: ext=%0b expected 0", ext_ctrl_d);
            miscompares++;
        end
        vectors++;
        tick();
        if (alu_ctrl_e !== 3'd3 || alub_sel_e !== 1'b1 || a3_e !== 5'd4) begin
            $display("FAIL ori_e: alu=%0d alub=%0b a3_e=%0d expected 3 1 4",
                     alu_ctrl_e, alub_sel_e, a3_e);
            miscompares++;
        end
        vectors++;
        instr_d = r_type(1, 2, 5, 'h23);           // subu $5,$1,$2
        tick();
        if (alu_ctrl_e !== 3'd1 || alub_sel_e !== 1'b0 || a3_e !== 5'd5) begin
            $display("FAIL subu_e: alu=%0d alub=%0b a3_e=%0d expected 1 0 5",
                     alu_ctrl_e, alub_sel_e, a3_e);
            miscompares++;
        end
        vectors++;
        instr_d = i_type('h2b, 1, 7, 0);           // sw $7,0($1)
        #1;
        if (ext_ctrl_d !== 1'b1) begin
            $display("FAIL sw_ext: ext=%0b expected 1", ext_ctrl_d);
            miscompares++;
        end
        vectors++;
        tick();
        instr_d = 32'd0;
        tick();
        if (dm_we_m !== 1'b1 || dm_re_m !== 1'b0 || a3_m !== 5'd0) begin
            $display("FAIL sw_m: dm_we_m=%0b dm_re_m=%0b a3_m=%0d expected 1 0 0",
                     dm_we_m, dm_re_m, a3_m);
            miscompares++;
        end
        vectors++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [8];
        logic [4:0]  exp_a3;
        prog[0] = i_type('h0d, 1, 4, 5);    exp_q.push_back(5'd4);   // ori
        prog[1] = i_type('h0f, 0, 5, 'h1234); exp_q.push_back(5'd5); // lui
        prog[2] = i_type('h09, 2, 6, 1);    exp_q.push_back(5'd6);   // addiu
        prog[3] = i_type('h2b, 1, 7, 0);    exp_q.push_back(5'd0);   // sw
        prog[4] = r_type(1, 2, 11, 'h2a);   exp_q.push_back(5'd11);  // slt
        prog[5] = 32'h0C00_0020;            exp_q.push_back(5'd31);  // jal
        prog[6] = i_type('h3f, 1, 13, 0);   exp_q.push_back(5'd0);   // unknown
        prog[7] = r_type(1, 2, 12, 'h23);   exp_q.push_back(5'd12);  // subu
        for (int i = 0; i < 10; i++) begin
            instr_d = (i < 8) ? prog[i] : 32'd0;
            tick();
            if (i >= 2) begin
                exp_a3 = exp_q.pop_front();
                if (a3_w !== exp_a3 || grf_we_w !== (exp_a3 != 5'd0)) begin
                    $display("FAIL b2b_wb[%0d]: a3_w=%0d grf_we_w=%0b expected %0d %0b",
                             i - 2, a3_w, grf_we_w, exp_a3, (exp_a3 != 5'd0));
                    miscompares++;
                end
                vectors++;
            end
        end
        drain();
    endtask

    task automatic test_branch_ext();
        instr_d = i_type('h01, 5, 0, 4);           // bltz $5
        cmp_lt  = 1'b1;
        #1;
`ifdef PIPE_CTRL_BRANCH_EXT_EN
        if (jump_ctrl_d !== 2'd1 || ext_ctrl_d !== 1'b1) begin
            $display("FAIL bltz_ext: jump=%0d ext=%0b expected 1 1", jump_ctrl_d, ext_ctrl_d);
            miscompares++;
        end
        vectors++;
        instr_d = i_type('h05, 1, 2, 4);           // bne $1,$2
        cmp_eq  = 1'b0;
        #1;
        if (jump_ctrl_d !== 2'd1) begin
            $display("FAIL bne_ext: jump=%0d expected 1", jump_ctrl_d);
            miscompares++;
        end
        vectors++;
`else
        if (jump_ctrl_d !== 2'd0 || ext_ctrl_d !== 1'b0) begin
            $display("FAIL bltz_nop: jump=%0d ext=%0b expected 0 0", jump_ctrl_d, ext_ctrl_d);
            miscompares++;
        end
        vectors++;
        tick();
        if (a3_e !== 5'd0 || mdu_op_e !== 3'd0 || alub_sel_e !== 1'b0) begin
            $display("FAIL bltz_nop_e: a3_e=%0d mdu_op_e=%0d alub=%0b expected 0 0 0",
                     a3_e, mdu_op_e, alub_sel_e);
            miscompares++;
        end
        vectors++;
`endif
        cmp_lt = 1'b0;
        drain();
    endtask

    // Test sequence and final report
    initial begin
        vectors     = 0;
        miscompares = 0;
        cmp_eq      = 1'b0;
        cmp_gt      = 1'b0;
        cmp_lt      = 1'b0;
        instr_d     = 32'd0;
        reset_n     = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_zero_write();
        test_decode();
        test_back_to_back();
        test_branch_ext();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Second-generation control unit for the 5-stage MIPS pipeline. Decodes the ID-stage instruction (base set plus mult/div/HI-LO ops), resolves branch and jump direction in ID, and detects stalls for load-use and multiply/divide-unit (MDU) busy hazards. It carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It replaces the purely combinational decoder plus external pipeline control registers.

Parameters:
MULT_CYCLES, 5, EX busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, EX busy cycles for div/divu (>=1)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
instr_d  in  32  ID-stage instruction
cmp_eq / cmp_gt / cmp_lt  in  1 each  ID comparator flags: rs==rt, rs>0, rs<0 (signed)
stall  out  1  hold PC and IF/ID; insert bubble into EX
jump_ctrl_d  out  2  0 = PC+4, 1 = branch target, 2 = j/jal target, 3 = jr
ext_ctrl_d  out  1  1 = sign-extend imm16
alu_ctrl_e  out  3  ALU op in EX
alub_sel_e  out  1  1 = ALU B input is the extended immediate
mdu_op_e  out  3  0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo
dm_we_m  out  1  data-memory write enable
dm_re_m  out  1  data-memory read enable
grf_we_w  out  1  register-file write enable
wd_sel_w  out  2  0 = ALU, 1 = DM, 2 = PC+8, 3 = HI/LO
a3_e / a3_m / a3_w  out  5 each  destination register per stage (0 if none)
mdu_busy  out  1  MDU counter non-zero

Behaviour:
- Reset (async, reset_n low): all E/M/W registered outputs, counter and mdu_busy go to 0 immediately. Comb outputs then follow decode of instr_d.
- Decode is combinational in ID. Unknown opcode/funct decodes as nop (all enables 0, a3 = 0).
- Destination register: rd for R-type and mfhi/mflo, rt for I-type loads/ALU, 31 for jal. A write to $0 forces a3 = 0 and grf_we = 0.
- Pipeline: on each clk edge, the D bundle moves to E, E to M, and M to W. Latency from instr_d to the E outputs is 1 cycle, to M is 2 cycles, and to W is 3 cycles.
- When stall = 1, the E registers load a bubble (all zeros) and M/W advance normally.
- Tuse (ID consumer): 0 for beq/jr (and extended branches); 1 for ALU/memory/MDU source reads.
- Load-use stall:
  - lw in E with a3_e matching a nonzero rs/rt of a D instruction with Tuse <= 1 -> stall.
  - lw in M with a3_m matching a D instruction with Tuse = 0 -> stall.
  - ALU/mfhi/mflo writer in E matching a D instruction with Tuse = 0 -> stall.
- Branch: beq is taken iff cmp_eq. jump_ctrl_d is computed even during a stall; upstream ignores it while stall = 1. The delay slot is always executed; there is no flush.
- MDU counter:
  - Loads MULT_CYCLES or DIV_CYCLES at the edge on which a mult/div op is in E.
  - Decrements to 0 otherwise. mdu_busy = (count != 0).
  - Counter width = $clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).
- MDU stall: a D-stage mult/div/mfhi/mflo/mthi/mtlo stalls while mdu_busy, or while a mult/div op is in E.
- A stall for load-use and a stall for MDU in the same cycle produce a single stall. A bubble in E never reloads the counter.

Optional Feature:
PIPE_CTRL_BRANCH_EXT_EN
- Defined: adds bne (!cmp_eq), bgez (!cmp_lt), bgtz (cmp_gt), blez (!cmp_gt), and bltz (cmp_lt). All are Tuse = 0 for rs, and bne also for rt. jump_ctrl_d = 1 when taken.
- Undefined: these opcodes decode as nop.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode/funct localparams
  - the ALU op, WD select, jump select and MDU op encodings
  - the packed control-bundle typedef
- Sub-module mdu_busy_timer (parametrised counter: load value, start, busy) is natural. The hazard compare logic stays inline.

Test Plan:
- Reset: drive reset_n = 0 mid-stream with lw in E -> within the same cycle a3_e = 0, dm_re_m = 0, mdu_busy = 0, stall = 0.
- Load-use: lw $8 followed by addu $9,$8,$8 -> stall = 1 for 1 cycle, EX bubble, addu reaches E one cycle later; lw then beq $8 -> 2 stall cycles.
- Branch: beq with cmp_eq = 1 -> jump_ctrl_d = 1; cmp_eq = 0 -> 0. jal -> a3_w = 31 and wd_sel_w = 2 three cycles later.
- MDU: mult then mflo (DEF params) -> mflo stalls 6 cycles (1 for E plus 5 busy), mdu_busy high 5 cycles. div then mfhi -> 11 stall cycles.
- $0 write: addu $0,$1,$2 -> grf_we_w = 0, a3_w = 0, and no stall for a following beq $0.
- With PIPE_CTRL_BRANCH_EXT_EN: bltz with cmp_lt = 1 -> jump_ctrl_d = 1. Without the macro, the same encoding -> jump_ctrl_d = 0 and all enables 0.
